// File: rtl/rgb_colour_sequencer.sv
// Six-colour RGB sequencer: button-edge or dwell-timer advance, registered colour/rgb/step outputs.
// Feeds the doorbell chime/light mux with a 24-bit {R,G,B} word.
module rgb_colour_sequencer #(
    parameter  int DWELL_TICKS = 50,
    localparam int CW          = $clog2(DWELL_TICKS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button,
    input  logic        auto_en,
    input  logic        hold,
    output logic [2:0]  colour,
    output logic [23:0] rgb,
    output logic        step
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_TICKS - 1);
    localparam logic [2:0]    COL_RST  = 3'b001;

    logic          s1_r;
    logic          s2_r;
    logic          s3_r;
    logic [2:0]    vld_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [2:0]    colour_r;
    logic [2:0]    colour_nxt_s;
    logic [23:0]   rgb_r;
    logic          step_r;
    logic          step_nxt_s;
    logic          btn_req_s;
    logic          tmr_req_s;
    logic          adv_s;

    function automatic logic [2:0] next_colour(input logic [2:0] c);
        case (c)
            3'b001:  return 3'b010;
            3'b010:  return 3'b011;
            3'b011:  return 3'b100;
            3'b100:  return 3'b101;
            3'b101:  return 3'b110;
            3'b110:  return 3'b001;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [23:0] colour_rgb(input logic [2:0] c);
        case (c)
            3'b001:  return 24'h0000FF;
            3'b010:  return 24'h00FF00;
            3'b011:  return 24'h00FFFF;
            3'b100:  return 24'hFF0000;
            3'b101:  return 24'hFF00FF;
            3'b110:  return 24'hFFFF00;
            default: return 24'h0000FF;
        endcase
    endfunction

    // Button synchroniser, edge-delay flop and sample-validity shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r  <= 1'b0;
            s2_r  <= 1'b0;
            s3_r  <= 1'b0;
            vld_r <= 3'b000;
        end else begin
            s1_r  <= button;
            s2_r  <= s1_r;
            s3_r  <= s2_r;
            vld_r <= {vld_r[1:0], 1'b1};
        end
    end

    // Advance requests; an edge is only believed once s3 holds a real post-reset sample,
    // so a button already held at release never fires.
    always_comb begin
        btn_req_s = s2_r & ~s3_r & vld_r[2];
        tmr_req_s = auto_en & (cnt_r == CNT_LAST);
        adv_s     = (btn_req_s | tmr_req_s) & ~hold;
    end

    // Dwell counter next value
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (!auto_en) begin
            cnt_nxt_s = '0;
        end else if (hold) begin
            cnt_nxt_s = cnt_r;
        end else if (adv_s) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
    end

    // Colour next state; illegal codes recover to blue ahead of hold and advance
    always_comb begin
        colour_nxt_s = colour_r;
        step_nxt_s   = 1'b0;
        if ((colour_r == 3'b000) || (colour_r == 3'b111)) begin
            colour_nxt_s = COL_RST;
            step_nxt_s   = 1'b0;
        end else if (adv_s) begin
            colour_nxt_s = next_colour(colour_r);
            step_nxt_s   = 1'b1;
        end else begin
            colour_nxt_s = colour_r;
            step_nxt_s   = 1'b0;
        end
    end

    // State and output registers; rgb is derived from the next colour so both update together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            colour_r <= COL_RST;
            rgb_r    <= 24'h0000FF;
            step_r   <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            colour_r <= colour_nxt_s;
            rgb_r    <= colour_rgb(colour_nxt_s);
            step_r   <= step_nxt_s;
        end
    end

    assign colour = colour_r;
    assign rgb    = rgb_r;
    assign step   = step_r;

endmodule
